// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-domain half of the asynchronous FIFO.
// Owns the read pointer, brings the write Gray pointer into rclk, drives the
// RAM read port and reports empty / almost-empty / underflow / level / count.
// Optional build macro: UNDERFLOW_STICKY_EN makes underflow a sticky flag
// cleared only by hw_rst_n or sw_rst; without it underflow is a 1-cycle pulse.
module fifo_rd_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic              rclk,
    input  logic              hw_rst_n,
    input  logic              sw_rst,
    input  logic              read_enable,
    input  logic [ADDR_W-1:0] aempty_value,
    input  logic [ADDR_W:0]   wptr_gray,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [ADDR_W:0]   rptr_gray,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              rdempty,
    output logic              rd_almost_empty,
    output logic              underflow,
    output logic [ADDR_W:0]   fifo_read_count,
    output logic [ADDR_W:0]   rd_level
);

    localparam int PW = ADDR_W + 1;

    logic [PW-1:0] wsync [SYNC_STAGES];
    logic [PW-1:0] wbin_s;
    logic [PW-1:0] rptr_bin;
    logic [PW-1:0] rptr_next;
    logic          rd_pending;
    logic          accept;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Synchroniser chain carrying the write Gray pointer into rclk.
    // NOTE: reset is synchronous here, so it is tested inside the clocked
    // block rather than listed in the sensitivity list.
    always_ff @(posedge rclk) begin
        if (!hw_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                wsync[i] <= '0;
            end
        end else begin
            wsync[0] <= wptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                wsync[i] <= wsync[i-1];
            end
        end
    end

    // Occupancy and status derived from the two registered pointers.
    assign wbin_s          = gray2bin(wsync[SYNC_STAGES-1]);
    assign rd_level        = wbin_s - rptr_bin;
    assign rdempty         = (rd_level == '0);
    assign rd_almost_empty = (rd_level <= {1'b0, aempty_value});

    // A read is accepted only when data is present and no reset/flush is active.
    assign accept    = hw_rst_n & ~sw_rst & read_enable & ~rdempty;
    assign mem_ren   = accept;
    assign mem_raddr = rptr_bin[ADDR_W-1:0];
    assign rptr_next = rptr_bin + PW'(1);

    // Pointer, count, read-data pipeline and underflow flag.
    // NOTE: every state register uses non-blocking assignment so all of them
    // update from the same pre-edge values regardless of statement order.
    always_ff @(posedge rclk) begin
        if (!hw_rst_n) begin
            rptr_bin        <= '0;
            rptr_gray       <= '0;
            fifo_read_count <= '0;
            rd_pending      <= 1'b0;
            rdata_valid     <= 1'b0;
            rdata           <= '0;
            underflow       <= 1'b0;
        end else if (sw_rst) begin
            // Flush: jump the read pointer to the write pointer, drop in-flight data.
            rptr_bin        <= wbin_s;
            rptr_gray       <= bin2gray(wbin_s);
            fifo_read_count <= '0;
            rd_pending      <= 1'b0;
            rdata_valid     <= 1'b0;
            underflow       <= 1'b0;
        end else begin
            if (accept) begin
                rptr_bin        <= rptr_next;
                rptr_gray       <= bin2gray(rptr_next);
                fifo_read_count <= fifo_read_count + PW'(1);
            end
            // RAM data arrives one cycle after the strobe; capture it then.
            rd_pending  <= accept;
            rdata_valid <= rd_pending;
            if (rd_pending) begin
                rdata <= mem_rdata;
            end
`ifdef UNDERFLOW_STICKY_EN
            underflow <= underflow | (read_enable & rdempty);
`else
            underflow <= read_enable & rdempty;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: directed scenarios followed by random
// traffic, all compared against a pointer-arithmetic model of the read side.
module tb_fifo_rd_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int SYNC   = 2;

    logic              rclk = 1'b0;
    logic              hw_rst_n;
    logic              sw_rst;
    logic              read_enable;
    logic [ADDR_W-1:0] aempty_value;
    logic [ADDR_W:0]   wptr_gray;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_raddr;
    logic [ADDR_W:0]   rptr_gray;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic              rdempty;
    logic              rd_almost_empty;
    logic              underflow;
    logic [ADDR_W:0]   fifo_read_count;
    logic [ADDR_W:0]   rd_level;

    fifo_rd_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_STAGES(SYNC)) dut (
        .rclk            (rclk),
        .hw_rst_n        (hw_rst_n),
        .sw_rst          (sw_rst),
        .read_enable     (read_enable),
        .aempty_value    (aempty_value),
        .wptr_gray       (wptr_gray),
        .mem_rdata       (mem_rdata),
        .mem_ren         (mem_ren),
        .mem_raddr       (mem_raddr),
        .rptr_gray       (rptr_gray),
        .rdata           (rdata),
        .rdata_valid     (rdata_valid),
        .rdempty         (rdempty),
        .rd_almost_empty (rd_almost_empty),
        .underflow       (underflow),
        .fifo_read_count (fifo_read_count),
        .rd_level        (rd_level)
    );

    always #5 rclk = ~rclk;

    // RAM: word at address a holds 0xA0 + a, returned one cycle after the strobe.
    logic [DATA_W-1:0] ram [32];
    initial for (int i = 0; i < 32; i++) ram[i] = 32'hA0 + i;
    initial mem_rdata = '0;
    always @(posedge rclk) if (mem_ren) mem_rdata <= ram[mem_raddr];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: write pointer seen after SYNC cycles, read pointer as
    // an integer mod 64, occupancy is their difference.
    int          wbin = 0;
    int          m_ws [SYNC];
    int          m_rptr = 0;
    int          m_cnt = 0;
    bit          m_pend = 0;
    int          m_pend_addr = 0;
    bit          m_valid = 0;
    bit          m_uf = 0;
    logic [31:0] m_rdata = '0;

    function automatic int m_level();
        return (m_ws[SYNC-1] - m_rptr) & 63;
    endfunction

    function automatic logic [5:0] gray6(input int b);
        logic [5:0] x;
        x = b[5:0];
        return x ^ (x >> 1);
    endfunction

    // One rclk cycle: drive inputs, check the read strobe, advance the model,
    // then check every registered/status output after the edge.
    task automatic step(input bit re, input bit sw, input bit rst, input int ae);
        int  lvl;
        int  old_last;
        bit  acc;
        bit  und;
        read_enable  = re;
        sw_rst       = sw;
        hw_rst_n     = ~rst;
        aempty_value = ae[ADDR_W-1:0];
        wptr_gray    = gray6(wbin);
        #1;
        lvl = m_level();
        acc = !rst && !sw && re && (lvl != 0);
        und = re && (lvl == 0);
        check("mem_ren", {31'd0, mem_ren}, {31'd0, acc});
        if (acc) check("mem_raddr", {27'd0, mem_raddr}, m_rptr & 31);
        if (rst) begin
            for (int i = 0; i < SYNC; i++) m_ws[i] = 0;
            m_rptr = 0; m_cnt = 0; m_pend = 0; m_valid = 0; m_uf = 0; m_rdata = '0;
        end else begin
            old_last = m_ws[SYNC-1];
            for (int i = SYNC - 1; i > 0; i--) m_ws[i] = m_ws[i-1];
            m_ws[0] = wbin;
            if (sw) begin
                m_rptr = old_last; m_cnt = 0; m_uf = 0; m_pend = 0; m_valid = 0;
            end else begin
`ifdef UNDERFLOW_STICKY_EN
                m_uf = m_uf || und;
`else
                m_uf = und;
`endif
                m_valid = m_pend;
                if (m_pend) m_rdata = ram[m_pend_addr];
                m_pend = acc;
                if (acc) begin
                    m_pend_addr = m_rptr & 31;
                    m_rptr = (m_rptr + 1) & 63;
                    m_cnt  = (m_cnt + 1) & 63;
                end
            end
        end
        @(posedge rclk);
        #1;
        lvl = m_level();
        check("rd_level", {26'd0, rd_level}, lvl);
        check("rdempty", {31'd0, rdempty}, {31'd0, lvl == 0});
        check("rd_almost_empty", {31'd0, rd_almost_empty}, {31'd0, lvl <= ae});
        check("rptr_gray", {26'd0, rptr_gray}, {26'd0, gray6(m_rptr)});
        check("rdata_valid", {31'd0, rdata_valid}, {31'd0, m_valid});
        check("rdata", rdata, m_rdata);
        check("underflow", {31'd0, underflow}, {31'd0, m_uf});
        check("fifo_read_count", {26'd0, fifo_read_count}, m_cnt);
    endtask

    // Move the write pointer and let it cross the synchroniser.
    task automatic set_w(input int w, input int ae);
        wbin = w & 63;
        for (int i = 0; i < SYNC; i++) step(0, 0, 0, ae);
    endtask

    logic [5:0] wrap_seq [5];

    initial begin
        wrap_seq[0] = 6'b100001; wrap_seq[1] = 6'b100000; wrap_seq[2] = 6'b000000;
        wrap_seq[3] = 6'b000001; wrap_seq[4] = 6'b000011;
        for (int i = 0; i < SYNC; i++) m_ws[i] = 0;
        hw_rst_n = 1'b0; sw_rst = 1'b0; read_enable = 1'b0;
        aempty_value = '0; wptr_gray = '0;

        // Reset held for two cycles.
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        check("reset_rdempty", {31'd0, rdempty}, 32'd1);
        check("reset_aempty", {31'd0, rd_almost_empty}, 32'd1);
        check("reset_rptr_gray", {26'd0, rptr_gray}, 32'd0);

        // Synchroniser latency and threshold compare.
        set_w(4, 4);
        check("sync_level4", {26'd0, rd_level}, 32'd4);
        check("aempty_at_4", {31'd0, rd_almost_empty}, 32'd1);
        step(0, 0, 0, 3);
        check("aempty_at_3", {31'd0, rd_almost_empty}, 32'd0);

        // Burst of four reads.
        for (int k = 0; k < 4; k++) step(1, 0, 0, 3);
        check("burst_empty", {31'd0, rdempty}, 32'd1);
        check("burst_count", {26'd0, fifo_read_count}, 32'd4);
        step(0, 0, 0, 3);
        check("burst_last_data", rdata, 32'hA3);

        // Read while empty.
        step(1, 0, 0, 0);
        check("underflow_set", {31'd0, underflow}, 32'd1);
        step(0, 0, 0, 0);

        // Walk the read pointer to 62 via flushes, then read across the wrap.
        set_w(34, 8); step(0, 1, 0, 8);
        set_w(62, 8); step(0, 1, 0, 8);
        set_w(2, 8);
        check("wrap_gray_start", {26'd0, rptr_gray}, {26'd0, wrap_seq[0]});
        for (int k = 1; k <= 4; k++) begin
            step(1, 0, 0, 8);
            check("wrap_gray_step", {26'd0, rptr_gray}, {26'd0, wrap_seq[k]});
        end
        check("wrap_level0", {26'd0, rd_level}, 32'd0);

        // Flush with a read in flight.
        set_w(8, 2);
        step(1, 0, 0, 2);
        step(1, 1, 0, 2);
        check("flush_level", {26'd0, rd_level}, 32'd0);
        check("flush_valid", {31'd0, rdata_valid}, 32'd0);
        check("flush_count", {26'd0, fifo_read_count}, 32'd0);

        // Hardware reset in the middle of a read.
        set_w(12, 2);
        step(1, 0, 0, 2);
        wbin = 0;
        step(1, 0, 1, 2);
        check("rst_mid_valid", {31'd0, rdata_valid}, 32'd0);

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            bit rst;
            bit sw;
            rst = ($urandom_range(0, 99) == 0);
            sw  = ($urandom_range(0, 39) == 0);
            if (rst) wbin = 0;
            else if ($urandom_range(0, 1) == 1 && (((wbin + 1 - m_rptr) & 63) <= 32))
                wbin = (wbin + 1) & 63;
            step(bit'($urandom_range(0, 1)), sw, rst, $urandom_range(0, 31));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
